// File: rtl/burst_ram_slave.sv
// Burst-capable single-port RAM slave on a shared OR-combined bus.
// Optional feature macro: BURST_RAM_BUSY_INJECT_EN (write busy stalls and read gaps).
module burst_ram_slave #(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int unsigned ADDR_BITS    = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        beginTransactionIn,
  input  logic [31:0] addressDataIn,
  input  logic [7:0]  burstSizeIn,
  input  logic        readNotWriteIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  output logic [31:0] addressDataOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  output logic        busyOut,
  output logic        busErrorOut
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_BITS;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    READ,
    READ_END,
    WRITE,
    ERROR
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [ADDR_BITS-1:0]   r_word;
  logic [1:0]             r_align;
  logic [7:0]             r_burst;
  logic                   r_read;
  logic [8:0]             r_beat_cnt;
  logic                   r_rd_valid;
  logic [31:0]            r_rdata;
  logic [31:0]            r_mem [0:DEPTH-1];

  logic                   w_sel;
  logic [8:0]             w_beats;
  logic [31:0]            w_end_word;
  logic                   w_decode_err;
  logic                   w_more;
  logic                   w_gap;
  logic                   w_busy;
  logic                   w_rd_issue;
  logic                   w_wr_accept;

  assign w_sel        = (addressDataIn[31:ADDR_BITS+2] == BASE_ADDRESS[31:ADDR_BITS+2]);
  assign w_beats      = 9'(r_burst) + 9'd1;
  assign w_end_word   = 32'(r_word) + 32'(r_burst) + 32'd1;
  assign w_decode_err = (r_align != 2'b00) || (w_end_word > DEPTH);
  assign w_more       = (r_beat_cnt < w_beats);
  assign w_rd_issue   = (r_state == READ) && !endTransactionIn && !w_gap && w_more;
  assign w_wr_accept  = (r_state == WRITE) && !endTransactionIn && dataValidIn && !w_busy && w_more;

  always_comb begin
    // NOTE: next state defaults to the current state so no path leaves it unassigned (no latch).
    w_next = r_state;
    case (r_state)
      IDLE:     if (beginTransactionIn && w_sel) w_next = DECODE;
      DECODE: begin
        if (endTransactionIn)  w_next = IDLE;
        else if (w_decode_err) w_next = ERROR;
        else if (r_read)       w_next = READ;
        else                   w_next = WRITE;
      end
      READ: begin
        if (endTransactionIn)                          w_next = IDLE;
        else if (r_rd_valid && (r_beat_cnt == w_beats)) w_next = READ_END;
      end
      WRITE:    if (endTransactionIn) w_next = IDLE;
      READ_END: w_next = IDLE;
      ERROR:    w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!reset) begin
      r_state    <= IDLE;
      r_word     <= '0;
      r_align    <= '0;
      r_burst    <= '0;
      r_read     <= 1'b0;
      r_beat_cnt <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rd_valid <= w_rd_issue;
      if (r_state == IDLE) begin
        r_beat_cnt <= '0;
        if (beginTransactionIn && w_sel) begin
          r_word  <= addressDataIn[ADDR_BITS+1:2];
          r_align <= addressDataIn[1:0];
          r_burst <= burstSizeIn;
          r_read  <= readNotWriteIn;
        end
      end else if (w_rd_issue || w_wr_accept) begin
        r_word     <= r_word + ADDR_BITS'(1);
        r_beat_cnt <= r_beat_cnt + 9'd1;
      end
    end
  end

  // NOTE: the RAM array has no reset so its contents survive a reset mid-burst.
  always_ff @(posedge clock) begin
    if (reset && w_wr_accept) r_mem[r_word] <= addressDataIn;
    if (w_rd_issue)           r_rdata       <= r_mem[r_word];
  end

`ifdef BURST_RAM_BUSY_INJECT_EN
  logic       r_gap;
  logic [1:0] r_busy_cnt;

  // Stall two cycles after every 4th accepted write; skip one issue after every 4th read.
  always_ff @(posedge clock) begin
    if (!reset || (r_state == IDLE)) begin
      r_gap      <= 1'b0;
      r_busy_cnt <= '0;
    end else begin
      r_gap <= w_rd_issue && (r_beat_cnt[1:0] == 2'b11) && ((r_beat_cnt + 9'd1) < w_beats);
      if (w_wr_accept && (r_beat_cnt[1:0] == 2'b11)) r_busy_cnt <= 2'd2;
      else if (r_busy_cnt != 2'd0)                   r_busy_cnt <= r_busy_cnt - 2'd1;
    end
  end

  assign w_gap  = r_gap;
  assign w_busy = (r_state == WRITE) && (r_busy_cnt != 2'd0);
`else
  assign w_gap  = 1'b0;
  assign w_busy = 1'b0;
`endif

  // Every output is zero outside the owning states so the bus can OR slaves together.
  assign dataValidOut      = (r_state == READ) && r_rd_valid;
  assign addressDataOut    = dataValidOut ? r_rdata : 32'h0;
  assign endTransactionOut = (r_state == READ_END) || (r_state == ERROR);
  assign busErrorOut       = (r_state == ERROR);
  assign busyOut           = w_busy;

endmodule

// File: tb/tb_burst_ram_slave.sv
// Randomized self-checking bench for burst_ram_slave against an array-based reference model.
module tb_burst_ram_slave;

  localparam logic [31:0] BASE  = 32'h5000_0000;
  localparam int          AB    = 10;
  localparam int          DEPTH = 1 << AB;
`ifdef BURST_RAM_BUSY_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        beginTransactionIn = 1'b0;
  logic [31:0] addressDataIn = '0;
  logic [7:0]  burstSizeIn = '0;
  logic        readNotWriteIn = 1'b0;
  logic        dataValidIn = 1'b0;
  logic        endTransactionIn = 1'b0;
  logic [31:0] addressDataOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic        busyOut;
  logic        busErrorOut;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] ref_mem [DEPTH];

  burst_ram_slave dut (
    .clock             (clock),
    .reset             (reset),
    .beginTransactionIn(beginTransactionIn),
    .addressDataIn     (addressDataIn),
    .burstSizeIn       (burstSizeIn),
    .readNotWriteIn    (readNotWriteIn),
    .dataValidIn       (dataValidIn),
    .endTransactionIn  (endTransactionIn),
    .addressDataOut    (addressDataOut),
    .dataValidOut      (dataValidOut),
    .endTransactionOut (endTransactionOut),
    .busyOut           (busyOut),
    .busErrorOut       (busErrorOut)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] bus_obs();
    return {busErrorOut, endTransactionOut, busyOut, dataValidOut, addressDataOut};
  endfunction

  function automatic logic [35:0] pack(bit err, bit en, bit bsy, bit vld, logic [31:0] d);
    return {err, en, bsy, vld, d};
  endfunction

  function automatic bit is_sel(logic [31:0] a);
    return a[31:AB+2] == BASE[31:AB+2];
  endfunction

  function automatic bit is_err(logic [31:0] a, int b);
    return (a[1:0] != 2'b00) || (int'(a[AB+1:2]) + b + 1 > DEPTH);
  endfunction

  // Cycle in which read beat j appears, counting the begin cycle as 0.
  function automatic int beat_cycle(int j);
    return 3 + j + (INJ ? j / 4 : 0);
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic start(input logic [31:0] a, input int b, input bit rnw);
    beginTransactionIn = 1'b1;
    addressDataIn      = a;
    burstSizeIn        = 8'(b);
    readNotWriteIn     = rnw;
  endtask

  // abort_after: number of beats delivered before endTransactionIn, -1 for none.
  task automatic do_read(input logic [31:0] a, input int b, input int abort_after);
    int idx, kend, ka, n, nshow;
    bit sel, err;
    logic [35:0] exp;
    idx   = int'(a[AB+1:2]);
    sel   = is_sel(a);
    err   = sel && is_err(a, b);
    kend  = beat_cycle(b) + 1;
    ka    = -1;
    nshow = b + 1;
    if (!sel)     n = 10;
    else if (err) n = 3;
    else          n = kend + 1;
    if (sel && !err && abort_after >= 1 && abort_after <= b) begin
      ka    = beat_cycle(abort_after - 1);
      nshow = abort_after;
      n     = ka + 2;
    end
    start(a, b, 1'b1);
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k == 1) begin
        beginTransactionIn = 1'b0;
        addressDataIn      = '0;
      end
      exp = '0;
      if (sel && err) begin
        if (k == 2) exp = pack(1, 1, 0, 0, 32'h0);
      end else if (sel) begin
        for (int j = 0; j < nshow; j++)
          if (k == beat_cycle(j)) exp = pack(0, 0, 0, 1, ref_mem[idx + j]);
        if (ka < 0 && k == kend) exp = pack(0, 1, 0, 0, 32'h0);
      end
      check($sformatf("rd@%h b%0d k%0d", a, b, k), 64'(bus_obs()), 64'(exp));
      endTransactionIn = (k == ka);
    end
    endTransactionIn = 1'b0;
  endtask

  // Sends b+1+extra beats (extra ones must be discarded), then ends the burst.
  task automatic do_write(input logic [31:0] a, input int b, input int extra, input bit seq_data);
    int idx, acc, sent, total, bcnt, phase, limit;
    bit sel, err, done, exp_busy;
    logic [31:0] d;
    idx   = int'(a[AB+1:2]);
    sel   = is_sel(a);
    err   = sel && is_err(a, b);
    acc   = 0;
    sent  = 0;
    bcnt  = 0;
    phase = 0;
    done  = 1'b0;
    total = b + 1 + extra;
    limit = total * 3 + 20;
    d     = seq_data ? 32'd10 : $urandom;
    start(a, b, 1'b0);
    tick();
    beginTransactionIn = 1'b0;
    addressDataIn      = '0;
    check($sformatf("wr@%h decode", a), 64'(bus_obs()), 64'(0));
    if (!sel || err) begin
      for (int k = 2; k <= (sel ? 3 : 10); k++) begin
        tick();
        check($sformatf("wr@%h k%0d", a, k), 64'(bus_obs()),
              64'((sel && k == 2) ? pack(1, 1, 0, 0, 32'h0) : 36'h0));
      end
      return;
    end
    for (int k = 2; k < limit && !done; k++) begin
      tick();
      if (phase == 1) begin
        check($sformatf("wr@%h post_end", a), 64'(bus_obs()), 64'(0));
        endTransactionIn = 1'b0;
        done = 1'b1;
      end else begin
        exp_busy = INJ && (bcnt > 0);
        check($sformatf("wr@%h k%0d", a, k), 64'(bus_obs()), 64'(pack(0, 0, exp_busy, 0, 32'h0)));
        if (bcnt > 0) bcnt--;
        if (sent == total) begin
          dataValidIn      = 1'b0;
          addressDataIn    = '0;
          endTransactionIn = 1'b1;
          phase            = 1;
        end else begin
          dataValidIn   = 1'b1;
          addressDataIn = d;
          if (!exp_busy) begin
            if (acc < b + 1) begin
              ref_mem[idx + acc] = d;
              acc++;
              if (acc % 4 == 0) bcnt = 2;
            end
            sent++;
            d = seq_data ? 32'(10 * (sent + 1)) : $urandom;
          end
        end
      end
    end
    if (!done) begin
      check("wr_timeout", 64'(0), 64'(1));
      dataValidIn      = 1'b0;
      endTransactionIn = 1'b0;
    end
  endtask

  task automatic reset_mid_read(input logic [31:0] a);
    int idx;
    logic [35:0] exp;
    idx = int'(a[AB+1:2]);
    start(a, 7, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) begin
        beginTransactionIn = 1'b0;
        addressDataIn      = '0;
      end
      exp = '0;
      if (k == 3) exp = pack(0, 0, 0, 1, ref_mem[idx]);
      if (k == 4) exp = pack(0, 0, 0, 1, ref_mem[idx + 1]);
      check($sformatf("rst_mid k%0d", k), 64'(bus_obs()), 64'(exp));
      if (k == 4) reset = 1'b0;
      if (k == 5) reset = 1'b1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, b, abort_n, extra;
    logic [31:0] a;
    repeat (3) tick();
    check("reset_outputs", 64'(bus_obs()), 64'(0));
    reset = 1'b1;
    tick();
    check("idle_outputs", 64'(bus_obs()), 64'(0));

    for (int q = 0; q < DEPTH / 256; q++) do_write(BASE + 32'(q * 1024), 255, 0, 1'b0);

    do_write(BASE, 2, 0, 1'b1);
    check("seq_word0", 64'(ref_mem[0]), 64'(10));
    do_read(BASE, 2, -1);
    do_read(BASE + 32'h2, 0, -1);
    do_read(BASE, 2, -1);
    do_read(BASE + 32'hFFC, 1, -1);
    do_read(BASE + 32'hFFC, 0, -1);
    do_read(32'h6000_0000, 3, -1);
    do_write(32'h6000_0000, 3, 0, 1'b0);
    do_read(BASE + 32'h10, 5, 2);
    do_read(BASE + 32'h40, 3, -1);
    do_write(BASE + 32'h80, 5, 0, 1'b0);
    do_read(BASE + 32'h80, 6, -1);
    do_write(BASE + 32'h320, 3, 2, 1'b0);
    do_read(BASE + 32'h320, 6, -1);
    do_read(BASE, 255, -1);
    reset_mid_read(BASE + 32'h20);

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      if (r < 7) begin
        a = BASE + 32'($urandom_range(0, DEPTH - 1 - b) * 4);
      end else if (r == 7) begin
        a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(1, 3));
      end else if (r == 8) begin
        if (b == 0) b = 1;
        a = BASE + 32'($urandom_range(DEPTH - b, DEPTH - 1) * 4);
      end else begin
        a = BASE ^ (32'h1 << $urandom_range(AB + 2, 31));
      end
      if ($urandom_range(0, 1) == 1) begin
        abort_n = ($urandom_range(0, 4) == 0 && b >= 1) ? $urandom_range(1, b) : -1;
        do_read(a, b, abort_n);
      end else begin
        extra = $urandom_range(0, 2);
        do_write(a, b, extra, 1'b0);
      end
    end

    for (int q = 0; q < DEPTH / 256; q++) do_read(BASE + 32'(q * 1024), 255, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/burst_ram_slave.md
BURST_RAM_SLAVE -- requirements
Module: burst_ram_slave

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h5000_0000, byte base address of the slave window.
REQ-002 SHALL have parameter ADDR_BITS, default 10, log2 of the number of 32-bit words held (default 1024 words).
REQ-003 SHALL have port clock  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous reset, active-low.
REQ-005 SHALL have port beginTransactionIn  in  1  master start strobe; address, burst size and direction are valid in this cycle.
REQ-006 SHALL have port addressDataIn  in  32  byte address during begin; write data during write beats.
REQ-007 SHALL have port burstSizeIn  in  8  beats minus one (0 = 1 beat, 255 = 256 beats).
REQ-008 SHALL have port readNotWriteIn  in  1  1 = read burst, 0 = write burst.
REQ-009 SHALL have port dataValidIn  in  1  write beat valid.
REQ-010 SHALL have port endTransactionIn  in  1  master end or abort strobe.
REQ-011 SHALL have port addressDataOut  in/out-bus  out  32  read data; 0 when not driving.
REQ-012 SHALL have port dataValidOut  out  1  read beat valid.
REQ-013 SHALL have port endTransactionOut  out  1  slave end of read burst or error.
REQ-014 SHALL have port busyOut  out  1  write-beat stall.
REQ-015 SHALL have port busErrorOut  out  1  selected-but-illegal request.

Function
REQ-016 SHALL drive all outputs to 0 whenever it is not the selected slave, so the outputs can be OR-combined onto the shared bus.
REQ-017 SHALL capture the address, burst size and direction on the clock edge where beginTransactionIn=1 and the FSM is IDLE; begin strobes outside IDLE are ignored.
REQ-018 SHALL treat a request as selected when address[31:ADDR_BITS+2] equals BASE_ADDRESS[31:ADDR_BITS+2]; an unselected request leaves the FSM in IDLE with no outputs.
REQ-019 SHALL have the FSM states IDLE, DECODE, READ, READ_END, WRITE and ERROR.
REQ-020 SHALL go from DECODE to ERROR when a selected request has address[1:0] != 0, or when word_index+burstSize+1 exceeds 2^ADDR_BITS; the burst is never wrapped.
REQ-021 In ERROR, SHALL assert busErrorOut and endTransactionOut together for exactly 1 cycle, then return to IDLE with no memory access.
REQ-022 For reads, SHALL issue one synchronous RAM read per cycle and assert dataValidOut on burstSize+1 consecutive cycles, the first at begin cycle T+3.
REQ-023 After the last read beat, SHALL enter READ_END and assert endTransactionOut for exactly 1 cycle, then return to IDLE.
REQ-024 For writes, SHALL accept a beat only in a cycle with dataValidIn=1 and busyOut=0; each accepted beat writes addressDataIn at the current word and advances the word address by 1.
REQ-025 SHALL return from WRITE to IDLE on endTransactionIn; beats beyond burstSize+1 are discarded.
REQ-026 SHALL abort any read or write when endTransactionIn=1 arrives mid-burst: outputs go to 0 the next cycle and the FSM returns to IDLE.
REQ-027 SHALL keep the beat counter 9 bits wide, so 256-beat bursts are covered without overflow.
REQ-028 Without the busy-injection feature, SHALL hold busyOut at 0.

Reset
REQ-029 On reset=0 at a clock edge, SHALL enter IDLE and clear all outputs, counters and latched request fields.
REQ-030 A reset mid-burst SHALL drop the burst with no further beats; RAM contents are preserved.

Configuration
REQ-031 The macro BURST_RAM_BUSY_INJECT_EN, when defined, SHALL make the block:
- assert busyOut for 2 cycles after every 4th accepted write beat;
- insert one idle cycle (dataValidOut=0) after every 4th read beat.
REQ-032 When BURST_RAM_BUSY_INJECT_EN is undefined, SHALL have no busy or read gaps and the timing of REQ-022 to REQ-024 applies unchanged.

Verification
REQ-033 SHALL pass: write to 0x5000_0000, burstSize=2, data 10/20/30, then endTransactionIn -> read back with burstSize=2 returns 10/20/30 on T+3..T+5, endTransactionOut at T+6.
REQ-034 SHALL pass: read at 0x5000_0002 -> busErrorOut=1 and endTransactionOut=1 at T+2 for 1 cycle; memory unchanged.
REQ-035 SHALL pass: read at 0x5000_0FFC, burstSize=1 (default depth) -> bus error; same request with burstSize=0 returns 1 beat.
REQ-036 SHALL pass: begin at 0x6000_0000 -> all outputs stay 0 for 10 cycles.
REQ-037 SHALL pass: 6-beat read, endTransactionIn after beat 2 -> no further dataValidOut; a new begin 2 cycles later is served normally.
REQ-038 SHALL pass, with BURST_RAM_BUSY_INJECT_EN defined: 6-beat write with dataValidIn held high -> busyOut=1 for 2 cycles after beat 4, and exactly 6 words are written.
